// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: the core's data SRAM port as one bundle.
//   data_sram_en    : access request this cycle (no back-pressure)
//   data_sram_we    : byte write enables, bit i -> wdata[8i+7:8i]; 0 = read
//   data_sram_addr  : byte address, addr[1:0] ignored
//   data_sram_wdata : write data
//   data_sram_rdata : registered read data, valid one cycle after the access
// Handshake: there is no valid/ready pair. Every cycle with data_sram_en=1 is
// an accepted access; data_sram_rdata for it is presented in the next cycle
// and holds until the next enabled access. master = core, slave = responder.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: responder for the core's data SRAM port.
// Single-port synchronous-read word RAM with byte write enables, plus a small
// register window at addr[31:16]==MMIO_BASE:
//   0x0000 TIMER   (RW, byte-writable, free-running; only with DATA_SRAM_TIMER_EN)
//   0x0004 LED     (RW, byte-writable, drives led)
//   0x0008 SCRATCH (RW, byte-writable)
//   0x000C ACC_CNT (RO, counts every enabled access)
//   other offsets read 0, writes ignored.
// Reads are read-first: rdata returns the location's value before this cycle's
// write. RAM contents are not reset; registers and rdata are.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : data_sram_resp_if.slave (en/we/addr/wdata in, rdata out)
//   led    : LED register value
// Optional feature macro: DATA_SRAM_TIMER_EN (TIMER register present when
// defined; otherwise offset 0x0000 reads 0 and ignores writes).
module data_sram_resp #(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] MMIO_BASE = 16'hbfaf
) (
  input  logic             clk,
  input  logic             resetn,
  data_sram_resp_if.slave  bus,
  output logic [31:0]      led
);

  localparam int RAM_WORDS = 1 << RAM_AW;

  // Replace the enabled bytes of old_val with the matching bytes of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0] mem [RAM_WORDS];

  logic              is_mmio;
  logic [13:0]       reg_idx;   // word offset inside the window; addr[1:0] dropped
  logic [RAM_AW-1:0] ram_idx;
  logic              is_write;
  logic              wr_led;
  logic              wr_scratch;

  logic [31:0] led_q;
  logic [31:0] scratch_q;
  logic [31:0] acc_q;
  logic [31:0] timer_val;
  logic [31:0] reg_rd;
  logic [31:0] rdata_q;

  assign is_mmio    = (bus.data_sram_addr[31:16] == MMIO_BASE);
  assign reg_idx    = bus.data_sram_addr[15:2];
  assign ram_idx    = bus.data_sram_addr[RAM_AW+1:2];
  assign is_write   = |bus.data_sram_we;
  assign wr_led     = bus.data_sram_en && is_mmio && is_write && (reg_idx == 14'd1);
  assign wr_scratch = bus.data_sram_en && is_mmio && is_write && (reg_idx == 14'd2);

`ifdef DATA_SRAM_TIMER_EN
  logic        wr_timer;
  logic [31:0] timer_q;

  assign wr_timer = bus.data_sram_en && is_mmio && is_write && (reg_idx == 14'd0);

  // A write wins over the increment; counting resumes from the written value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else if (wr_timer) begin
      timer_q <= merge_bytes(timer_q, bus.data_sram_wdata, bus.data_sram_we);
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  // Writable registers and the access counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q     <= '0;
      scratch_q <= '0;
      acc_q     <= '0;
    end else begin
      if (wr_led)     led_q     <= merge_bytes(led_q, bus.data_sram_wdata, bus.data_sram_we);
      if (wr_scratch) scratch_q <= merge_bytes(scratch_q, bus.data_sram_wdata, bus.data_sram_we);
      // Every enabled access counts, including writes to ACC_CNT itself
      // and to unmapped offsets.
      if (bus.data_sram_en) acc_q <= acc_q + 32'd1;
    end
  end

  // Register read mux; values are the pre-edge contents, which is what gives
  // read-first behaviour for the window.
  always_comb begin
    reg_rd = '0;
    case (reg_idx)
      14'd0:   reg_rd = timer_val;
      14'd1:   reg_rd = led_q;
      14'd2:   reg_rd = scratch_q;
      14'd3:   reg_rd = acc_q;
      default: reg_rd = '0;
    endcase
  end

  // RAM array: no reset on the contents. Address bits above RAM_AW+1 are not
  // decoded, so the RAM aliases across the non-window address space.
  always_ff @(posedge clk) begin
    if (bus.data_sram_en && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_we[i]) mem[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read data register. The RAM read samples the old word in the same edge
  // as any write, so RAM reads are read-first too. Holds when en=0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (bus.data_sram_en) begin
      rdata_q <= is_mmio ? reg_rd : mem[ram_idx];
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led                 = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: self-checking bench for data_sram_resp.
// Table-driven vectors plus hand-written sequences for the timer wrap and an
// asynchronous reset in the middle of traffic. Expected read data is pushed
// to exp_q when an access is driven and popped when rdata is sampled.
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic [31:0] led;

  data_sram_resp_if bus ();

  data_sram_resp dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .led    (led)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          acc_model = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One bus cycle: drive inputs, let the edge happen, sample 1ns later.
  task automatic do_access(input logic en, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic chk, input logic [31:0] exp,
                           input string name);
    logic [31:0] e;
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    if (chk) exp_q.push_back(exp);
    if (en) acc_model++;
    @(posedge clk);
    #1;
    bus.data_sram_en = 1'b0;
    bus.data_sram_we = 4'h0;
    if (chk) begin
      e = exp_q.pop_front();
      check(name, bus.data_sram_rdata, e);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    logic        chk_led;
    logic [31:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] t0, t1, t2;

    // RAM byte writes and read-first
    vecs.push_back('{1'b1, 4'hf, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0,          1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h2, 32'h0000_0100, 32'h0000_AA00, 1'b1, 32'h1122_3344,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 32'h1122_AA44,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hf, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hf, 32'h0000_0200, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF,  1'b0, 32'h0});
    // ACC_CNT after 5 accesses, then the write-then-read of 0x200
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_000C, 32'h0,         1'b1, 32'd5,          1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0200, 32'h0,         1'b1, 32'h1234_5678,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_000C, 32'h0,         1'b1, 32'd7,          1'b0, 32'h0});
    // idle: rdata holds, counter unchanged
    vecs.push_back('{1'b0, 4'hf, 32'hbfaf_0004, 32'hFFFF_FFFF, 1'b1, 32'd7,          1'b1, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_000C, 32'h0,         1'b1, 32'd8,          1'b0, 32'h0});
    // LED register
    vecs.push_back('{1'b1, 4'hf, 32'hbfaf_0004, 32'h0000_00A5, 1'b1, 32'h0,          1'b1, 32'h0000_00A5});
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_0004, 32'h0,         1'b1, 32'h0000_00A5,  1'b1, 32'h0000_00A5});
    vecs.push_back('{1'b1, 4'h4, 32'hbfaf_0004, 32'h0033_0000, 1'b1, 32'h0000_00A5,  1'b1, 32'h0033_00A5});
    // unmapped offset reads 0; ACC_CNT write ignored but counted
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_0010, 32'h0,         1'b1, 32'h0,          1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hf, 32'hbfaf_000C, 32'hFFFF_FFFF, 1'b1, 32'd13,         1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_000C, 32'h0,         1'b1, 32'd14,         1'b0, 32'h0});
    // SCRATCH
    vecs.push_back('{1'b1, 4'hf, 32'hbfaf_0008, 32'hCAFE_F00D, 1'b1, 32'h0,          1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h1, 32'hbfaf_0008, 32'h0000_00AA, 1'b1, 32'hCAFE_F00D,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_0008, 32'h0,         1'b1, 32'hCAFE_F0AA,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hf, 32'hbfaf_0010, 32'h0000_1234, 1'b1, 32'h0,          1'b0, 32'h0});
    // top RAM word, aliasing above RAM_AW, window-adjacent RAM, addr[1:0] ignored
    vecs.push_back('{1'b1, 4'hf, 32'h0000_FFFC, 32'hA5A5_5A5A, 1'b0, 32'h0,          1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0001_FFFC, 32'h0,         1'b1, 32'hA5A5_5A5A,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'hbfae_0100, 32'h0,         1'b1, 32'h1122_AA44,  1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'hbfaf_0007, 32'h0,         1'b1, 32'h0033_00A5,  1'b1, 32'h0033_00A5});

    // ---------------- reset ----------------
    resetn              = 1'b0;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", bus.data_sram_rdata, 32'h0);
    check("reset_led", led, 32'h0);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    acc_model = 0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      do_access(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].chk, vecs[i].exp, $sformatf("vec%0d_rdata", i));
      if (vecs[i].chk_led) check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
    end

    // ---------------- timer wrap ----------------
`ifdef DATA_SRAM_TIMER_EN
    t0 = 32'hFFFF_FFFE; t1 = 32'hFFFF_FFFF; t2 = 32'h0;
`else
    t0 = 32'h0; t1 = 32'h0; t2 = 32'h0;
`endif
    do_access(1'b1, 4'hf, 32'hbfaf_0000, 32'hFFFF_FFFE, 1'b0, 32'h0, "timer_wr");
    do_access(1'b1, 4'h0, 32'hbfaf_0000, 32'h0, 1'b1, t0, "timer_rd0");
    do_access(1'b1, 4'h0, 32'hbfaf_0000, 32'h0, 1'b1, t1, "timer_rd1");
    do_access(1'b1, 4'h0, 32'hbfaf_0000, 32'h0, 1'b1, t2, "timer_wrap");

    // running access count from the bench's own tally
    do_access(1'b1, 4'h0, 32'hbfaf_000C, 32'h0, 1'b1, acc_model, "acc_total");

    // ---------------- async reset mid-stream ----------------
    bus.data_sram_en   = 1'b1;
    bus.data_sram_we   = 4'h0;
    bus.data_sram_addr = 32'hbfaf_0004;
    #3;
    resetn           = 1'b0;
    bus.data_sram_en = 1'b0;
    #1;
    check("async_rst_rdata", bus.data_sram_rdata, 32'h0);
    check("async_rst_led", led, 32'h0);
    @(posedge clk);
    #1;
    check("in_rst_rdata", bus.data_sram_rdata, 32'h0);
    #2 resetn = 1'b1;
    acc_model = 0;
    @(posedge clk);
    #1;
    check("post_rst_rdata", bus.data_sram_rdata, 32'h0);
    do_access(1'b1, 4'h0, 32'hbfaf_000C, 32'h0, 1'b1, 32'd0,         "post_rst_acc");
    do_access(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 32'h1122_AA44, "post_rst_ram100");
    do_access(1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b1, 32'h1234_5678, "post_rst_ram200");
    do_access(1'b1, 4'h0, 32'hbfaf_0004, 32'h0, 1'b1, 32'h0,         "post_rst_led_reg");
    do_access(1'b1, 4'h0, 32'hbfaf_0008, 32'h0, 1'b1, 32'h0,         "post_rst_scratch");
    do_access(1'b1, 4'h0, 32'hbfaf_000C, 32'h0, 1'b1, acc_model,     "post_rst_acc2");

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
